// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parametrised UART transmitter fed by a valid/ready word handshake
// Frame: start, DATA_BITS LSB first, optional parity, STOP_BITS stop bits; tx is registered.
module uart_tx_param #(
  parameter int CLK_FREQ     = 10000000,
  parameter int BAUDRATE     = 115200,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUDRATE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 busy,
  output logic                 tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 bit_done;

  assign bit_done = (cnt == CNT_LAST);
  assign busy     = ~tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
    end else begin
      // Bit-period counter runs in every non-idle state and wraps at each bit boundary.
      if (state != S_IDLE) begin
        cnt <= bit_done ? '0 : cnt + CW'(1);
      end
      case (state)
        S_IDLE: begin
          if (tx_valid) begin
            shreg    <= tx_data;
            par_bit  <= (PARITY == 1) ? ~(^tx_data) : (^tx_data);
            state    <= S_START;
            tx       <= 1'b0;
            tx_ready <= 1'b0;
            cnt      <= '0;
            idx      <= '0;
          end
        end
        S_START: begin
          if (bit_done) begin
            state <= S_DATA;
            tx    <= shreg[0];
          end
        end
        S_DATA: begin
          if (bit_done) begin
            shreg <= shreg >> 1;
            if (idx == DATA_LAST) begin
              idx <= '0;
              if (PARITY != 0) begin
                state <= S_PARITY;
                tx    <= par_bit;
              end else begin
                state <= S_STOP;
                tx    <= 1'b1;
              end
            end else begin
              idx <= idx + IW'(1);
              tx  <= shreg[1];
            end
          end
        end
        S_PARITY: begin
          if (bit_done) begin
            state <= S_STOP;
            tx    <= 1'b1;
          end
        end
        S_STOP: begin
          // idx is reused to count stop bits.
          if (bit_done) begin
            if (idx == STOP_LAST) begin
              idx      <= '0;
              state    <= S_IDLE;
              tx_ready <= 1'b1;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          tx       <= 1'b1;
          tx_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
